pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_reg_chain_if.sv | 31 +++
 rtl/pipe_reg_stage.sv | 45 ++++
 rtl/pipe_reg_chain.sv | 85 ++++++++
 tb/tb_pipe_reg_chain.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipelined register chain.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_DEPTH  = 2;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned MAX_DEPTH  = 8;

    // Number of set bits in a stage-valid vector (zero-extended to MAX_DEPTH).
    function automatic logic [3:0] popcount(input logic [MAX_DEPTH-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_DEPTH); i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Upstream/downstream handshake bundle for pipe_reg_chain plus its status outputs.
interface pipe_reg_chain_if #(
    parameter int unsigned DATA_W = pipe_pkg::DEF_DATA_W,
    parameter int unsigned CTRL_W = pipe_pkg::DEF_CTRL_W,
    parameter int unsigned DEPTH  = pipe_pkg::DEF_DEPTH,
    parameter int unsigned CNT_W  = pipe_pkg::DEF_CNT_W
) ();
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy, drop_cnt
    );
endinterface

// File: rtl/pipe_reg_stage.sv
// One valid/data/ctrl register stage with hold, bubble insertion and flush.
module pipe_reg_stage #(
    parameter int unsigned DATA_W = pipe_pkg::DEF_DATA_W,
    parameter int unsigned CTRL_W = pipe_pkg::DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_ready,
    input  logic              i_up_valid,
    input  logic [DATA_W-1:0] i_up_data,
    input  logic [CTRL_W-1:0] i_up_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Data is only ever cleared by reset; bubbles and flushes keep the old payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_ready) begin
            if (i_up_valid) begin
                r_valid <= 1'b1;
                r_data  <= i_up_data;
                r_ctrl  <= i_up_ctrl;
            end else begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain of DEPTH stages with flush, occupancy and saturating drop counter.
module pipe_reg_chain #(
    parameter int unsigned DATA_W = pipe_pkg::DEF_DATA_W,
    parameter int unsigned CTRL_W = pipe_pkg::DEF_CTRL_W,
    parameter int unsigned DEPTH  = pipe_pkg::DEF_DEPTH,
    parameter int unsigned CNT_W  = pipe_pkg::DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_reg_chain_if.slave    bus
);
    import pipe_pkg::*;

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 4;

    logic [DEPTH-1:0]  w_valid;
    logic [DATA_W-1:0] w_data [DEPTH];
    logic [CTRL_W-1:0] w_ctrl [DEPTH];
    logic [DEPTH:0]    w_ready;
    logic [3:0]        w_pop;
    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_max;
    logic [CNT_W-1:0]  r_drop_cnt;

    assign w_ready[DEPTH] = bus.out_ready;

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        logic              w_up_valid;
        logic [DATA_W-1:0] w_up_data;
        logic [CTRL_W-1:0] w_up_ctrl;

        if (k == 0) begin : g_head
            assign w_up_valid = bus.in_valid;
            assign w_up_data  = bus.in_data;
            assign w_up_ctrl  = bus.in_ctrl;
        end else begin : g_body
            assign w_up_valid = w_valid[k-1];
            assign w_up_data  = w_data[k-1];
            assign w_up_ctrl  = w_ctrl[k-1];
        end

        assign w_ready[k] = ~w_valid[k] | w_ready[k+1];

        pipe_reg_stage #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_flush    (bus.flush),
            .i_ready    (w_ready[k]),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .i_up_ctrl  (w_up_ctrl),
            .o_valid    (w_valid[k]),
            .o_data     (w_data[k]),
            .o_ctrl     (w_ctrl[k])
        );
    end

    assign w_pop = popcount(MAX_DEPTH'(w_valid));
    assign w_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_pop);
    assign w_max = SUM_W'({CNT_W{1'b1}});

    // Every beat still valid on a flush edge is lost; count it, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (bus.flush) begin
            if (w_sum > w_max) begin
                r_drop_cnt <= {CNT_W{1'b1}};
            end else begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(w_pop);
            end
        end
    end

    assign bus.in_ready  = w_ready[0] & ~bus.flush;
    assign bus.out_valid = w_valid[DEPTH-1] & ~bus.flush;
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.out_ctrl  = bus.out_valid ? w_ctrl[DEPTH-1] : '0;
    assign bus.occupancy = OCC_W'(w_pop);
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomized checks of pipe_reg_chain at DEPTH=3, DATA_W=32, CTRL_W=4.
module tb_pipe_reg_chain;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned DP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    pipe_reg_chain_if #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP), .CNT_W(16)) bus_a ();
    pipe_reg_chain_if #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP), .CNT_W(2))  bus_b ();

    // Second instance mirrors the stimulus; it exists only to see the 2-bit counter saturate.
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.in_ctrl   = bus_a.in_ctrl;
    assign bus_b.flush     = bus_a.flush;
    assign bus_b.out_ready = bus_a.out_ready;

    pipe_reg_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP), .CNT_W(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pipe_reg_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] c);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        bus_a.in_ctrl  = c;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [35:0] q[$];
        logic [35:0] exp_beat;

        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.in_ctrl   = '0;
        bus_a.flush     = 1'b0;
        bus_a.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_occ",    64'(bus_a.occupancy), 0);
        chk("rst_ovalid", 64'(bus_a.out_valid), 0);
        chk("rst_iready", 64'(bus_a.in_ready),  1);
        chk("rst_drop",   64'(bus_a.drop_cnt),  0);
        chk("rst_odata",  64'(bus_a.out_data),  0);
        chk("rst_octrl",  64'(bus_a.out_ctrl),  0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Streaming with out_ready=1: three-cycle latency
        push(32'h11, 4'h1);
        push(32'h22, 4'h2);
        push(32'h33, 4'h3);
        bus_a.in_valid = 1'b0;
        chk("s_v0",   64'(bus_a.out_valid), 1);
        chk("s_d0",   64'(bus_a.out_data),  64'h11);
        chk("s_c0",   64'(bus_a.out_ctrl),  1);
        chk("s_occ0", 64'(bus_a.occupancy), 3);
        step();
        chk("s_d1",   64'(bus_a.out_data),  64'h22);
        chk("s_c1",   64'(bus_a.out_ctrl),  2);
        chk("s_occ1", 64'(bus_a.occupancy), 2);
        step();
        chk("s_d2",   64'(bus_a.out_data),  64'h33);
        chk("s_c2",   64'(bus_a.out_ctrl),  3);
        chk("s_occ2", 64'(bus_a.occupancy), 1);
        step();
        chk("s_vend", 64'(bus_a.out_valid), 0);
        chk("s_cend", 64'(bus_a.out_ctrl),  0);
        chk("s_oend", 64'(bus_a.occupancy), 0);

        // Backpressure at full, then a simultaneous pop and push
        bus_a.out_ready = 1'b0;
        push(32'h11, 4'h1);
        push(32'h22, 4'h2);
        push(32'h33, 4'h3);
        bus_a.in_data = 32'h44;
        bus_a.in_ctrl = 4'h4;
        chk("bp_iready", 64'(bus_a.in_ready),  0);
        chk("bp_data",   64'(bus_a.out_data),  64'h11);
        chk("bp_occ",    64'(bus_a.occupancy), 3);
        step();
        chk("bp_hold",   64'(bus_a.out_data),  64'h11);
        chk("bp_occh",   64'(bus_a.occupancy), 3);
        bus_a.out_ready = 1'b1;
        #1;
        chk("bp_iready1", 64'(bus_a.in_ready), 1);
        step();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b0;
        chk("pp_data", 64'(bus_a.out_data),  64'h22);
        chk("pp_ctrl", 64'(bus_a.out_ctrl),  2);
        chk("pp_occ",  64'(bus_a.occupancy), 3);

        // Flush of a full chain
        bus_a.flush = 1'b1;
        #1;
        chk("fl_ovalid", 64'(bus_a.out_valid), 0);
        chk("fl_octrl",  64'(bus_a.out_ctrl),  0);
        chk("fl_iready", 64'(bus_a.in_ready),  0);
        step();
        bus_a.flush = 1'b0;
        chk("fl_occ",   64'(bus_a.occupancy), 0);
        chk("fl_ctrl",  64'(bus_a.out_ctrl),  0);
        chk("fl_vld",   64'(bus_a.out_valid), 0);
        chk("fl_drop",  64'(bus_a.drop_cnt),  3);
        chk("fl_dropb", 64'(bus_b.drop_cnt),  3);
        chk("fl_data",  64'(bus_a.out_data),  64'h22);

        // Three more full flushes: wide counter accumulates, narrow one saturates
        for (int r = 0; r < 3; r++) begin
            push(32'(r * 16 + 1), 4'h5);
            push(32'(r * 16 + 2), 4'h6);
            push(32'(r * 16 + 3), 4'h7);
            bus_a.in_valid = 1'b0;
            bus_a.flush    = 1'b1;
            step();
            bus_a.flush = 1'b0;
        end
        chk("sat_dropa", 64'(bus_a.drop_cnt),  12);
        chk("sat_dropb", 64'(bus_b.drop_cnt),  3);
        chk("sat_occ",   64'(bus_a.occupancy), 0);

        // Half-cycle reset mid-stream
        bus_a.out_ready = 1'b1;
        push(32'h55, 4'h5);
        push(32'h66, 4'h6);
        push(32'h77, 4'h7);
        bus_a.in_valid = 1'b0;
        chk("rm_pre", 64'(bus_a.out_data), 64'h55);
        rst_n = 1'b0;
        #1;
        chk("rm_vld",  64'(bus_a.out_valid), 0);
        chk("rm_occ",  64'(bus_a.occupancy), 0);
        chk("rm_data", 64'(bus_a.out_data),  0);
        chk("rm_drop", 64'(bus_a.drop_cnt),  0);
        chk("rm_rdy",  64'(bus_a.in_ready),  1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        push(32'h88, 4'h8);
        push(32'h99, 4'h9);
        push(32'haa, 4'ha);
        bus_a.in_valid = 1'b0;
        chk("rr_d0", 64'(bus_a.out_data), 64'h88);
        chk("rr_c0", 64'(bus_a.out_ctrl), 8);
        step();
        chk("rr_d1", 64'(bus_a.out_data), 64'h99);
        step();
        chk("rr_d2", 64'(bus_a.out_data), 64'haa);
        step();
        chk("rr_drop", 64'(bus_a.drop_cnt), 0);
        chk("rr_occ",  64'(bus_a.occupancy), 0);

        // Random traffic against an in-order scoreboard
        for (int i = 0; i < 10010; i++) begin
            if (i < 10000) begin
                bus_a.in_valid  = 1'($urandom_range(0, 1));
                bus_a.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus_a.in_valid  = 1'b0;
                bus_a.out_ready = 1'b1;
            end
            bus_a.in_data = $urandom;
            bus_a.in_ctrl = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("rnd_occ", 64'(bus_a.occupancy), 64'(q.size()));
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra", 64'(1), 64'(0));
                end else begin
                    exp_beat = q.pop_front();
                    chk("rnd_beat", 64'({bus_a.out_ctrl, bus_a.out_data}), 64'(exp_beat));
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                q.push_back({bus_a.in_ctrl, bus_a.in_data});
            end
            step();
        end
        chk("rnd_left",  64'(q.size()),        0);
        chk("rnd_occ0",  64'(bus_a.occupancy), 0);
        chk("rnd_ctrl0", 64'(bus_a.out_ctrl),  0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
